menu_game_ctrl: RTL and testbench



---
 rtl/menu_game_ctrl_pkg.sv | 20 ++
 rtl/menu_game_ctrl_frame_tick_gen.sv | 22 ++
 rtl/menu_game_ctrl.sv | 135 +++++++++++++
 tb/tb_menu_game_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/menu_game_ctrl_pkg.sv
// Shared encodings for the game sequencer: game states, menu option indices
// and a small elaboration-time helper.
package menu_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_MENU      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_RESULT    = 2'd3
    } game_state_t;

    localparam logic [1:0] OPT_START = 2'd0;
    localparam logic [1:0] OPT_GEAR  = 2'd1;
    localparam logic [1:0] OPT_DIFF  = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/menu_game_ctrl_frame_tick_gen.sv
// Vsync rising-edge detector: one-cycle tick in the first cycle vsync_in is
// sampled high. Also used by the car and animation blocks.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
        end
    end

    assign tick = vsync_in & ~vsync_q;

endmodule

// File: rtl/menu_game_ctrl.sv
// Game sequencer: MENU -> COUNTDOWN -> RACE -> RESULT, with menu options,
// start-light countdown, race timer and winner latch. All outputs registered.
//
// state        | meaning
// ST_MENU      | option navigation; enter on START begins the countdown
// ST_COUNTDOWN | start lights step down once per FRAMES_PER_SEC ticks
// ST_RACE      | race_time counts frames until car logic reports race_done
// ST_RESULT    | winner shown for RESULT_FRAMES ticks or until enter
module menu_game_ctrl
    import menu_game_ctrl_pkg::*;
#(
    parameter int N_OPTIONS      = 3,
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNT_FROM     = 3,
    parameter int RESULT_FRAMES  = 180,
    parameter int N_DIFF         = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_enter,
    input  logic        race_done,
    input  logic        winner_in,
    output logic [1:0]  game_state,
    output logic [1:0]  menu_sel,
    output logic [1:0]  countdown_val,
    output logic        go_pulse,
    output logic [15:0] race_time,
    output logic        winner,
    output logic        auto_gear,
    output logic [1:0]  difficulty
);

    // Floor of 2 keeps the counter at least one bit wide for tiny parameters.
    localparam int FC_MAX = max_int(max_int(FRAMES_PER_SEC, RESULT_FRAMES), 2);
    localparam int FCW    = $clog2(FC_MAX);

    localparam logic [FCW-1:0] FPS_LAST = FCW'(FRAMES_PER_SEC - 1);
    localparam logic [FCW-1:0] RES_LAST = FCW'(RESULT_FRAMES - 1);
    localparam logic [FCW-1:0] FC_ONE   = FCW'(1);
    localparam logic [1:0]     SEL_LAST = 2'(N_OPTIONS - 1);
    localparam logic [1:0]     DIFF_LAST = 2'(N_DIFF - 1);
    localparam logic [1:0]     CD_START = 2'(COUNT_FROM);

    game_state_t    state;
    logic [FCW-1:0] frame_cnt;
    logic           frame_tick;

    frame_tick_gen u_frame_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .tick     (frame_tick)
    );

    assign game_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_MENU;
            menu_sel      <= 2'd0;
            countdown_val <= 2'd0;
            go_pulse      <= 1'b0;
            race_time     <= 16'd0;
            winner        <= 1'b0;
            auto_gear     <= 1'b0;
            difficulty    <= 2'd0;
            frame_cnt     <= '0;
        end else begin
            go_pulse <= 1'b0;
            case (state)
                ST_MENU: begin
                    // Enter wins over up/down arriving in the same cycle.
                    if (key_enter) begin
                        case (menu_sel)
                            OPT_START: begin
                                state         <= ST_COUNTDOWN;
                                countdown_val <= CD_START;
                                frame_cnt     <= '0;
                                race_time     <= 16'd0;
                            end
                            OPT_GEAR: auto_gear <= ~auto_gear;
                            OPT_DIFF: difficulty <= (difficulty >= DIFF_LAST) ? 2'd0
                                                                              : difficulty + 2'd1;
                            default: ;
                        endcase
                    end else if (key_down && !key_up) begin
                        menu_sel <= (menu_sel >= SEL_LAST) ? 2'd0 : menu_sel + 2'd1;
                    end else if (key_up && !key_down) begin
                        menu_sel <= (menu_sel == 2'd0) ? SEL_LAST : menu_sel - 2'd1;
                    end
                end
                ST_COUNTDOWN: begin
                    if (frame_tick) begin
                        if (frame_cnt == FPS_LAST) begin
                            frame_cnt <= '0;
                            if (countdown_val == 2'd1) begin
                                countdown_val <= 2'd0;
                                state         <= ST_RACE;
                                go_pulse      <= 1'b1;
                            end else begin
                                countdown_val <= countdown_val - 2'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FC_ONE;
                        end
                    end
                end
                ST_RACE: begin
                    if (frame_tick && race_time != 16'hFFFF) begin
                        race_time <= race_time + 16'd1;
                    end
                    if (race_done) begin
                        winner    <= winner_in;
                        frame_cnt <= '0;
                        state     <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (key_enter || (frame_tick && frame_cnt == RES_LAST)) begin
                        state     <= ST_MENU;
                        menu_sel  <= 2'd0;
                        frame_cnt <= '0;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt + FC_ONE;
                    end
                end
                default: state <= ST_MENU;
            endcase
        end
    end

endmodule

// File: tb/tb_menu_game_ctrl.sv
// Directed bench for menu_game_ctrl: table-driven menu vectors followed by
// hand-written countdown, race, result and reset sequences.
module tb_menu_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync_in, key_up, key_down, key_enter, race_done, winner_in;
    logic [1:0]  game_state, menu_sel, countdown_val, difficulty;
    logic        go_pulse, winner, auto_gear;
    logic [15:0] race_time;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  sel;
        logic [1:0]  cd;
        logic        go;
        logic [15:0] rt;
        logic        win;
        logic        ag;
        logic [1:0]  diff;
    } outs_t;

    typedef struct packed {
        logic  up;
        logic  down;
        logic  enter;
        outs_t exp;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    go_cnt = 0;
    outs_t act;
    vec_t  vecs[17];

    menu_game_ctrl #(
        .N_OPTIONS      (3),
        .FRAMES_PER_SEC (2),
        .COUNT_FROM     (3),
        .RESULT_FRAMES  (4),
        .N_DIFF         (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vsync_in      (vsync_in),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_enter     (key_enter),
        .race_done     (race_done),
        .winner_in     (winner_in),
        .game_state    (game_state),
        .menu_sel      (menu_sel),
        .countdown_val (countdown_val),
        .go_pulse      (go_pulse),
        .race_time     (race_time),
        .winner        (winner),
        .auto_gear     (auto_gear),
        .difficulty    (difficulty)
    );

    always #5 clk = ~clk;

    assign act = {game_state, menu_sel, countdown_val, go_pulse, race_time,
                  winner, auto_gear, difficulty};

    always @(negedge clk) if (go_pulse === 1'b1) go_cnt++;

    function automatic outs_t mk(input logic [1:0] st, input logic [1:0] sel,
                                 input logic [1:0] cd, input logic go,
                                 input logic [15:0] rt, input logic win,
                                 input logic ag, input logic [1:0] diff);
        return {st, sel, cd, go, rt, win, ag, diff};
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, a, e);
        end
    endtask

    task automatic cyc(input logic u, input logic d, input logic e,
                       input logic v, input logic rd, input logic wi);
        key_up = u; key_down = d; key_enter = e;
        vsync_in = v; race_done = rd; winner_in = wi;
        @(posedge clk);
        #1;
        key_up = 0; key_down = 0; key_enter = 0;
        vsync_in = 0; race_done = 0; winner_in = 0;
    endtask

    task automatic tick();
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // up, down, enter, expected {st, sel, cd, go, rt, win, ag, diff}
        vecs[0]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 1, 0)};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{1'b0, 1'b1, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{1'b0, 1'b0, 1'b1, mk(0, 2, 0, 0, 0, 0, 0, 1)};
        vecs[12] = '{1'b0, 1'b0, 1'b1, mk(0, 2, 0, 0, 0, 0, 0, 2)};
        vecs[13] = '{1'b0, 1'b0, 1'b1, mk(0, 2, 0, 0, 0, 0, 0, 0)};
        vecs[14] = '{1'b0, 1'b1, 1'b1, mk(0, 2, 0, 0, 0, 0, 0, 1)};
        vecs[15] = '{1'b0, 1'b0, 1'b0, mk(0, 2, 0, 0, 0, 0, 0, 1)};
        vecs[16] = '{1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1)};

        rst = 1; vsync_in = 0; key_up = 0; key_down = 0; key_enter = 0;
        race_done = 0; winner_in = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_outputs", 32'(act), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].up, vecs[i].down, vecs[i].enter, 0, 0, 0);
            chk($sformatf("menu_vec%0d", i), 32'(act), 32'(vecs[i].exp));
        end

        // Countdown: 3 -> 2 -> 1 -> RACE, two ticks per step, keys ignored
        cyc(0, 0, 1, 0, 0, 0);
        chk("cd_enter", 32'(act), 32'(mk(1, 0, 3, 0, 0, 0, 0, 1)));
        cyc(0, 1, 1, 0, 0, 0);
        chk("cd_keys_ignored", 32'(act), 32'(mk(1, 0, 3, 0, 0, 0, 0, 1)));
        tick(); tick();
        chk("cd_val2", 32'(countdown_val), 32'd2);
        tick(); tick();
        chk("cd_val1", 32'(countdown_val), 32'd1);
        tick();
        chk("cd_val1_hold", 32'(act), 32'(mk(1, 0, 1, 0, 0, 0, 0, 1)));
        cyc(0, 0, 0, 1, 0, 0);
        chk("cd_go", 32'(act), 32'(mk(2, 0, 0, 1, 0, 0, 0, 1)));
        cyc(0, 0, 0, 0, 0, 0);
        chk("go_one_cycle", 32'(go_pulse), 32'd0);

        // Race: 5 ticks, then race_done freezes race_time
        repeat (5) tick();
        chk("race_time5", 32'(race_time), 32'd5);
        cyc(0, 0, 0, 0, 1, 1);
        chk("race_done", 32'(act), 32'(mk(3, 0, 0, 0, 5, 1, 0, 1)));
        tick();
        chk("race_time_frozen", 32'(race_time), 32'd5);
        cyc(0, 1, 0, 0, 0, 0);
        chk("result_down_ignored", 32'({game_state, menu_sel}), 32'({2'd3, 2'd0}));
        tick(); tick();
        chk("result_hold3", 32'(game_state), 32'd3);
        tick();
        chk("result_timeout", 32'(act), 32'(mk(0, 0, 0, 0, 5, 1, 0, 1)));
        cyc(0, 1, 0, 0, 0, 0);
        chk("menu_after_result", 32'(menu_sel), 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("menu_back_start", 32'(menu_sel), 32'd0);

        // Second race: race_done coinciding with a tick still counts it
        cyc(0, 0, 1, 0, 0, 0);
        chk("start2_rt_clear", 32'({game_state, race_time}), 32'({2'd1, 16'd0}));
        repeat (6) tick();
        chk("race2", 32'(game_state), 32'd2);
        tick(); tick();
        cyc(0, 0, 0, 1, 1, 0);
        chk("done_with_tick", 32'(act), 32'(mk(3, 0, 0, 0, 3, 0, 0, 1)));
        cyc(0, 0, 0, 0, 0, 0);
        tick();
        chk("result2_hold", 32'(game_state), 32'd3);
        cyc(0, 0, 1, 0, 0, 0);
        chk("result_enter_exit", 32'(game_state), 32'd0);

        // Third race: vsync held high yields a single tick
        cyc(0, 0, 1, 0, 0, 0);
        repeat (6) tick();
        chk("race3", 32'({game_state, race_time}), 32'({2'd2, 16'd0}));
        vsync_in = 1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("vsync_held_one_tick", 32'(race_time), 32'd1);
        vsync_in = 0;
        cyc(0, 0, 0, 0, 0, 0);
        tick();
        chk("vsync_retick", 32'(race_time), 32'd2);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("back_to_menu", 32'(game_state), 32'd0);

        // Reset during countdown
        cyc(0, 0, 1, 0, 0, 0);
        tick(); tick();
        chk("cd_before_rst", 32'({game_state, countdown_val}), 32'({2'd1, 2'd2}));
        rst = 1; vsync_in = 1;
        @(posedge clk);
        #1;
        rst = 0; vsync_in = 0;
        chk("rst_mid_countdown", 32'(act), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_stays_idle", 32'(act), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        chk("go_pulse_count", 32'(go_cnt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
